accumulator_bank: RTL and testbench
===================================

// Module: accumulator_bank
// PURPOSE
//  Multi-channel successor to the single 17-bit MAC accumulator: CHANNELS independent
//  accumulators, indexed per beat, fed by the multiplier stage. Valid/ready input; a
//  one-entry output register emits a channel's total on its last beat, then re-arms it.
//  Sits between the multiplier array and the result writeback path.
// PARAMETERS
//  IN_W      16  width of unsigned input product
//  ACC_W     17  accumulator width; must be >= IN_W+1
//  CHANNELS  4   number of accumulators, >= 2
//  CH_W (localparam) = $clog2(CHANNELS)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept beat
//  in_data    in   IN_W   product to accumulate (unsigned)
//  in_ch      in   CH_W   target channel
//  in_clear   in   1      load in_data instead of adding
//  in_last    in   1      final beat of channel's sum; emit result
//  out_valid  out  1      result held in output register
//  out_ready  in   1      downstream accepts result
//  out_ch     out  CH_W   channel of result
//  out_data   out  ACC_W  accumulated total
//  out_ovf    out  1      sticky overflow of that total
// BEHAVIOUR
//  - Reset (rst_n low, async): all acc[i]=0, ovf[i]=0; out_valid=0, out_data=0,
//    out_ch=0, out_ovf=0. Takes effect mid-operation; in-flight result is discarded.
//  - in_ready = !out_valid || out_ready (combinational); same rule for all beats.
//  - Accept = in_valid && in_ready. Non-accepted cycles change no state.
//  - Accepted beat, ch=in_ch: sum = acc[ch] + zero-extended in_data (ACC_W+1 bits).
//    in_clear=1: acc'=in_data, ovf'=0. in_clear=0: acc'=sum[ACC_W-1:0],
//    ovf' = ovf[ch] | sum[ACC_W].
//  - in_last=1 on accepted beat: next cycle out_valid=1, out_ch=ch, out_data=acc',
//    out_ovf=ovf'; acc[ch] and ovf[ch] reset to 0 (not to acc'). Latency: 1 cycle.
//  - in_clear && in_last same beat: out_data=in_data, out_ovf=0.
//  - Output handshake: out_valid && out_ready retires result. Simultaneous retire and new
//    last beat: register reloads same cycle, out_valid stays 1 (no bubble).
//  - out_* stable while out_valid && !out_ready.
//  - in_ch >= CHANNELS (non-power-of-2 CHANNELS): beat accepted and dropped, no state change,
//    no output even if in_last.
//  - Channels fully independent; beats to other channels never disturb acc[ch].
// CONFIGURATION
//  ACC_SAT_EN defined: non-clear add with sum[ACC_W]=1 saturates acc' to 2^ACC_W-1
//    (all ones); ovf' still set; further adds hold at all ones.
//  ACC_SAT_EN undefined: wrap modulo 2^ACC_W as above. Ports identical in both builds.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> all outputs 0 immediately; after release ch0 clear+last
//    in_data=5 -> out_data=5.
//  2 ch1: clear 100, add 200, add 300 last -> out_valid next cycle, out_ch=1, out_data=600,
//    out_ovf=0; next ch1 add 7 last -> 7 (auto re-arm).
//  3 Defaults, ch2: clear 0xFFFF, add 0xFFFF, add 2 last -> wrap: out_data=0x00000, out_ovf=1;
//    with ACC_SAT_EN: out_data=0x1FFFF, out_ovf=1.
//  4 Backpressure: out_ready=0, ch0 last then ch3 beat -> in_ready=0, out_* held; raise
//    out_ready -> retire and accept ch3 same cycle.
//  5 Interleave ch0/ch1/ch2/ch3 adds of 1..4 each x3, then lasts -> totals 3,6,9,12, no crosstalk.

Source files
------------

// File: rtl/accumulator_bank.sv
// Multi-channel accumulator bank with valid/ready input and a one-entry result register.
// Build option: define ACC_SAT_EN to saturate on overflow instead of wrapping.
module accumulator_bank #(
  parameter int IN_W     = 16,
  parameter int ACC_W    = 17,
  parameter int CHANNELS = 4,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CH_W-1:0]  in_ch,
  input  logic             in_clear,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  logic [ACC_W-1:0] acc [CHANNELS];
  logic             ovf [CHANNELS];

  logic             accept;
  logic             ch_ok;
  logic             hit;
  logic [CH_W:0]    ch_ext;
  logic [ACC_W-1:0] acc_cur;
  logic             ovf_cur;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // Widened compare keeps the range check meaningful for non-power-of-2 channel counts.
  assign ch_ext   = {1'b0, in_ch};
  assign ch_ok    = ch_ext < (CH_W+1)'(CHANNELS);
  assign hit      = accept && ch_ok;

  always_comb begin
    acc_cur = '0;
    ovf_cur = 1'b0;
    if (ch_ok) begin
      acc_cur = acc[in_ch];
      ovf_cur = ovf[in_ch];
    end
    sum = {1'b0, acc_cur} + {{(ACC_W+1-IN_W){1'b0}}, in_data};
    if (in_clear) begin
      acc_nxt = {{(ACC_W-IN_W){1'b0}}, in_data};
      ovf_nxt = 1'b0;
    end else begin
`ifdef ACC_SAT_EN
      acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc_nxt = sum[ACC_W-1:0];
`endif
      ovf_nxt = ovf_cur | sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
        ovf[i] <= 1'b0;
      end
    end else if (hit) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (in_ch == CH_W'(i)) begin
          // A last beat re-arms the channel; its total lives on in the output register.
          acc[i] <= in_last ? '0 : acc_nxt;
          ovf[i] <= in_last ? 1'b0 : ovf_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (hit && in_last) begin
        out_valid <= 1'b1;
        out_ch    <= in_ch;
        out_data  <= acc_nxt;
        out_ovf   <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed bench for accumulator_bank: arithmetic model checked every cycle plus literal results.
module tb_accumulator_bank;
  localparam int IN_W = 16;
  localparam int ACC_W = 17;
  localparam int CHANNELS = 4;
  localparam int CH_W = 2;
  localparam longint MOD = 64'd1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic [CH_W-1:0]  in_ch = '0;
  logic             in_clear = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CH_W-1:0]  out_ch;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  accumulator_bank #(.IN_W(IN_W), .ACC_W(ACC_W), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
    .in_clear(in_clear), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-channel running totals as plain integers
  longint macc [CHANNELS];
  bit     movf [CHANNELS];
  bit     m_valid;
  int     m_ch;
  longint m_data;
  bit     m_ovf;

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      macc[i] = 0;
      movf[i] = 0;
    end
    m_valid = 0; m_ch = 0; m_data = 0; m_ovf = 0;
  endtask

  initial model_reset();

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc_ok;
      longint t;
      bit o;
      acc_ok = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid = 0;
      if (acc_ok && int'(in_ch) < CHANNELS) begin
        if (in_clear) begin
          t = longint'(in_data);
          o = 0;
        end else begin
          t = macc[in_ch] + longint'(in_data);
          o = movf[in_ch] || (t >= MOD);
`ifdef ACC_SAT_EN
          if (t >= MOD) t = MOD - 1;
`else
          if (t >= MOD) t = t - MOD;
`endif
        end
        if (in_last) begin
          m_valid = 1; m_ch = int'(in_ch); m_data = t; m_ovf = o;
          macc[in_ch] = 0; movf[in_ch] = 0;
        end else begin
          macc[in_ch] = t; movf[in_ch] = o;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_ch", out_ch, m_ch);
      chk("out_data", out_data, m_data);
      chk("out_ovf", out_ovf, m_ovf);
    end
  end

  // Retired results, compared against hand-computed literals
  typedef struct { int ch; longint data; bit ovf; } res_t;
  res_t res_q[$];

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      res_t r;
      r.ch = int'(out_ch); r.data = longint'(out_data); r.ovf = out_ovf;
      res_q.push_back(r);
    end
  end

  task automatic beat(input int ch, input int data, input bit clr, input bit last);
    int n;
    in_valid = 1'b1; in_ch = CH_W'(ch); in_data = IN_W'(data);
    in_clear = clr; in_last = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_clear = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_result(input string name, input int ch, input longint data, input bit ovf);
    res_t r;
    int n;
    n = 0;
    while (res_q.size() == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (res_q.size() == 0) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      r = res_q.pop_front();
      chk({name, "_ch"}, r.ch, ch);
      chk({name, "_data"}, r.data, data);
      chk({name, "_ovf"}, r.ovf, ovf);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset mid-stream with a result held under backpressure
    out_ready = 1'b0;
    beat(2, 50, 1'b0, 1'b0);
    beat(1, 3, 1'b0, 1'b1);
    chk("t1_held_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", out_valid, 0);
    chk("t1_rst_data", out_data, 0);
    chk("t1_rst_ch", out_ch, 0);
    chk("t1_rst_ovf", out_ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_q.delete();
    out_ready = 1'b1;
    beat(0, 5, 1'b1, 1'b1);
    expect_result("t1", 0, 5, 0);

    // 2: ch1 sum of three beats, then auto re-arm
    beat(1, 100, 1'b1, 1'b0);
    beat(1, 200, 1'b0, 1'b0);
    beat(1, 300, 1'b0, 1'b1);
    chk("t2_latency", out_valid, 1);
    expect_result("t2a", 1, 600, 0);
    beat(1, 7, 1'b0, 1'b1);
    expect_result("t2b", 1, 7, 0);

    // 3: overflow on ch2
    beat(2, 'hFFFF, 1'b1, 1'b0);
    beat(2, 'hFFFF, 1'b0, 1'b0);
    beat(2, 2, 1'b0, 1'b1);
`ifdef ACC_SAT_EN
    expect_result("t3", 2, 'h1FFFF, 1);
`else
    expect_result("t3", 2, 'h00000, 1);
`endif

    // 4: backpressure, then retire and accept in the same cycle
    out_ready = 1'b0;
    beat(0, 9, 1'b1, 1'b1);
    in_valid = 1'b1; in_ch = 2'd3; in_data = 16'd4; in_clear = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t4_stall_ready", in_ready, 0);
      chk("t4_hold_data", out_data, 9);
      chk("t4_hold_ch", out_ch, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_ready_rise", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_clear = 1'b0; in_last = 1'b0;
    chk("t4_no_bubble", out_valid, 1);
    expect_result("t4a", 0, 9, 0);
    expect_result("t4b", 3, 4, 0);

    // 5: interleaved channels, no crosstalk
    for (int rep = 0; rep < 3; rep++)
      for (int c = 0; c < CHANNELS; c++)
        beat(c, c + 1, 1'b0, 1'b0);
    for (int c = 0; c < CHANNELS; c++)
      beat(c, 0, 1'b0, 1'b1);
    expect_result("t5_ch0", 0, 3, 0);
    expect_result("t5_ch1", 1, 6, 0);
    expect_result("t5_ch2", 2, 9, 0);
    expect_result("t5_ch3", 3, 12, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
